// File: rtl/mul256_op_inv.sv
// Sequential modular inverse x = a^-1 mod m (odd m) via binary extended Euclid,
// one add/subtract/halve step per cycle. Optional cycle counter: MUL256_OP_INV_CYCLE_CNT_EN.
module mul256_op_inv #(
    parameter int P_WIDTH = 260,
    parameter int P_CW    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] m,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [P_WIDTH-1:0] x
`ifdef MUL256_OP_INV_CYCLE_CNT_EN
    ,
    output logic [P_CW-1:0]    cyc
`endif
);

    localparam int AW = P_WIDTH + 1;
    localparam logic [AW-1:0]      A_ONE = AW'(1);
    localparam logic [P_WIDTH-1:0] M_ONE = P_WIDTH'(1);

    // Handshake: start is sampled only in S_IDLE; busy is high in S_CHK/S_LOOP;
    // done is a one-cycle pulse in S_FIN, with x/err already valid and held until the next accepted start.
    typedef enum logic [1:0] {
        S_IDLE,
        S_CHK,
        S_LOOP,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      u_q, u_d;
    logic [AW-1:0]      v_q, v_d;
    logic [AW-1:0]      x1_q, x1_d;
    logic [AW-1:0]      x2_q, x2_d;
    logic [P_WIDTH-1:0] rm_q, rm_d;
    logic               err_q, err_d;
    logic [P_WIDTH-1:0] x_q, x_d;

    logic [AW-1:0] rm_ext;
    logic [AW-1:0] x1_half, x2_half, x1_sub, x2_sub;
    logic          in_bad;

    // x1/x2 stay below rm, so x+rm never overflows AW bits and the wrapped
    // difference plus rm lands back in [0, rm-1].
    always_comb begin
        rm_ext  = {1'b0, rm_q};
        x1_half = x1_q[0] ? ((x1_q + rm_ext) >> 1) : (x1_q >> 1);
        x2_half = x2_q[0] ? ((x2_q + rm_ext) >> 1) : (x2_q >> 1);
        x1_sub  = (x1_q >= x2_q) ? (x1_q - x2_q) : (x1_q - x2_q + rm_ext);
        x2_sub  = (x2_q >= x1_q) ? (x2_q - x1_q) : (x2_q - x1_q + rm_ext);
        in_bad  = !rm_q[0] || (rm_q <= M_ONE) || (u_q == '0) || (u_q >= rm_ext);
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        rm_d    = rm_q;
        err_d   = err_q;
        x_d     = x_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    u_d     = {1'b0, a};
                    v_d     = {1'b0, m};
                    rm_d    = m;
                    x1_d    = A_ONE;
                    x2_d    = '0;
                    err_d   = 1'b0;
                    x_d     = '0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (in_bad) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                if (u_q == A_ONE || v_q == A_ONE) begin
                    // Result is registered here so it is already valid during the done cycle.
                    x_d     = (u_q == A_ONE) ? x1_q[P_WIDTH-1:0] : x2_q[P_WIDTH-1:0];
                    state_d = S_FIN;
                end else if (u_q == '0 || v_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_half;
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_half;
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_sub;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_sub;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            rm_q    <= '0;
            err_q   <= 1'b0;
            x_q     <= '0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            rm_q    <= rm_d;
            err_q   <= err_d;
            x_q     <= x_d;
        end
    end

    assign busy = (state_q == S_CHK) || (state_q == S_LOOP);
    assign done = (state_q == S_FIN);
    assign err  = err_q;
    assign x    = x_q;

`ifdef MUL256_OP_INV_CYCLE_CNT_EN
    logic [P_CW-1:0] cyc_q, cyc_d;

    // Counts every cycle from the accepted start through done, so it reads the
    // start-to-done latency once the operation has finished.
    always_comb begin
        cyc_d = cyc_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                cyc_d = '0;
            end
        end else if (cyc_q != {P_CW{1'b1}}) begin
            cyc_d = cyc_q + P_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign cyc = cyc_q;
`endif

endmodule

// File: tb/tb_mul256_op_inv.sv
// Self-checking bench for mul256_op_inv: directed corner cases plus randomized
// operands checked against a plain extended-Euclid reference model.
module tb_mul256_op_inv;

    localparam int W       = 260;
    localparam int CW      = 16;
    localparam int LAT_MAX = 4 * W + 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] x;
`ifdef MUL256_OP_INV_CYCLE_CNT_EN
    logic [CW-1:0] cyc;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];

    logic [W-1:0] p;

    always #5 clk = ~clk;

    mul256_op_inv #(
        .P_WIDTH(W),
        .P_CW   (CW)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .m    (m),
        .busy (busy),
        .done (done),
        .err  (err),
        .x    (x)
`ifdef MUL256_OP_INV_CYCLE_CNT_EN
        ,
        .cyc  (cyc)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: textbook extended Euclid on wide integers, with legality rules applied first.
    function automatic void model_inv(input logic [W-1:0] ai, input logic [W-1:0] mi,
                                      output logic e, output logic [W-1:0] xo);
        logic [2*W-1:0] r, nr, t, nt, q, tmp, mm;
        if (!mi[0] || mi <= 1 || ai == 0 || ai >= mi) begin
            e  = 1'b1;
            xo = '0;
            return;
        end
        mm = {{W{1'b0}}, mi};
        r  = mm;
        nr = {{W{1'b0}}, ai};
        t  = '0;
        nt = 1;
        while (nr != 0) begin
            q   = r / nr;
            tmp = (t + mm - ((q * nt) % mm)) % mm;
            t   = nt;
            nt  = tmp;
            tmp = r - q * nr;
            r   = nr;
            nr  = tmp;
        end
        if (r != 1) begin
            e  = 1'b1;
            xo = '0;
        end else begin
            e  = 1'b0;
            xo = t[W-1:0];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] ai, input logic [W-1:0] mi);
        logic         e;
        logic [W-1:0] xo;
        model_inv(ai, mi, e, xo);
        exp_q.push_back(xo);
        exp_err_q.push_back(e);
        a     = ai;
        m     = mi;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for done; optionally fires a new start on the done cycle.
    task automatic wait_done(input string tag, input bit inject,
                             output logic [W-1:0] xg, output logic eg, output int lat);
        logic [W-1:0] ex;
        logic         ee;
        lat = 1;
        while (!done && lat <= LAT_MAX) begin
            tick();
            lat++;
        end
        ex = exp_q.size() > 0 ? exp_q.pop_front() : '0;
        ee = exp_err_q.size() > 0 ? exp_err_q.pop_front() : 1'b0;
        xg = x;
        eg = err;
        check({tag, "_done_seen"}, W'(done), W'(1));
        check({tag, "_lat_bound"}, W'(lat <= LAT_MAX), W'(1));
        check({tag, "_x"}, x, ex);
        check({tag, "_err"}, W'(err), W'(ee));
        check({tag, "_busy_at_done"}, W'(busy), W'(0));
        if (inject) begin
            a     = 3;
            m     = 7;
            start = 1'b1;
        end
        tick();
        start = 1'b0;
        check({tag, "_done_one_pulse"}, W'(done), W'(0));
        check({tag, "_x_held"}, x, ex);
        if (inject) begin
            check({tag, "_start_on_done_ignored"}, W'(busy), W'(0));
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ai, input logic [W-1:0] mi,
                          output logic [W-1:0] xg, output logic eg, output int lat);
        do_start(ai, mi);
        wait_done(tag, 1'b0, xg, eg, lat);
    endtask

    function automatic logic [W-1:0] rand_wide();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < 9; i++) begin
            r = (r << 32) | W'($urandom);
        end
        return r;
    endfunction

    initial begin
        logic [W-1:0]   xg;
        logic           eg;
        int             lat;
        logic [W-1:0]   ai, mi;
        logic [2*W-1:0] prod;
        int             seen;

        p     = (W'(1) << 256) - (W'(1) << 32) - W'(977);
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        m     = '0;
        tick();
        tick();
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_x", x, '0);
        rst = 1'b0;
        tick();

        run_op("a3m7", 3, 7, xg, eg, lat);
        check("a3m7_const", xg, 5);
        run_op("a1m7", 1, 7, xg, eg, lat);
        check("a1m7_const", xg, 1);
        check("a1m7_lat", W'(lat), W'(3));
`ifdef MUL256_OP_INV_CYCLE_CNT_EN
        check("cyc_after_done", W'(cyc), W'(3));
        tick();
        tick();
        check("cyc_held", W'(cyc), W'(3));
        do_start(3, 7);
        check("cyc_cleared", W'(cyc), W'(0));
        wait_done("cyc_op", 1'b0, xg, eg, lat);
`endif

        run_op("a6m9", 6, 9, xg, eg, lat);
        check("a6m9_err_const", W'(eg), W'(1));
        check("a6m9_x_const", xg, '0);
        run_op("a2m8", 2, 8, xg, eg, lat);
        check("a2m8_err_const", W'(eg), W'(1));
        check("a2m8_lat", W'(lat), W'(2));
        run_op("a0m7", 0, 7, xg, eg, lat);
        check("a0m7_err_const", W'(eg), W'(1));
        run_op("a7m7", 7, 7, xg, eg, lat);
        check("a7m7_err_const", W'(eg), W'(1));
        run_op("a1m1", 1, 1, xg, eg, lat);
        check("a1m1_err_const", W'(eg), W'(1));

        run_op("p_a2", 2, p, xg, eg, lat);
        check("p_a2_half", xg, (p + W'(1)) >> 1);

        // start while busy: second request with a=5 must not disturb the first
        do_start(3, 7);
        a     = 5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", 1'b0, xg, eg, lat);
        check("busy_start_const", xg, 5);

        // start on the done cycle is ignored; the following start is accepted
        do_start(1, 7);
        wait_done("done_start", 1'b1, xg, eg, lat);
        run_op("after_done", 3, 7, xg, eg, lat);
        check("after_done_const", xg, 5);

        for (int i = 0; i < 50; i++) begin
            ai = (rand_wide() % (p - W'(1))) + W'(1);
            run_op("p_rand", ai, p, xg, eg, lat);
            prod = ({{W{1'b0}}, ai} * {{W{1'b0}}, xg}) % {{W{1'b0}}, p};
            check("p_rand_prod", prod[W-1:0], W'(1));
        end

        for (int i = 0; i < 30; i++) begin
            mi = W'($urandom_range(65535, 2));
            if ($urandom_range(3, 0) != 0) begin
                mi[0] = 1'b1;
            end
            ai = W'($urandom_range(32'(mi) + 1, 0));
            run_op("small_rand", ai, mi, xg, eg, lat);
        end

        // reset mid-operation aborts with no done pulse
        do_start(rand_wide() % (p - W'(1)) + W'(1), p);
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_done", W'(done), W'(0));
        check("midrst_err", W'(err), W'(0));
        check("midrst_x", x, '0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen++;
            end
            tick();
        end
        check("midrst_no_done", W'(seen), W'(0));
        run_op("post_rst", 3, 7, xg, eg, lat);
        check("post_rst_const", xg, 5);

        check("sb_empty", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
